interruption_controller: RTL

- Consumes the 2-bit interruption code from the watchdog stage: 0 = none, 1 = user request, 2 = automatic timeout, 3 = reserved.
- Latches each event as a sticky pending bit and arbitrates between them.
- Hands one interrupt at a time to the control unit at an instruction boundary, saving the return PC and supplying the handler vector.
- Its in_handler output drives the watchdog's is_kernel input, which holds the watchdog counter cleared while a handler runs.

---
 rtl/interruption_controller_if.sv | 35 +++
 rtl/interruption_controller.sv | 122 ++++++++++++
 2 files changed

// File: rtl/interruption_controller_if.sv
// Interruption controller bus: watchdog event code and control-unit
// handshake on one side, handler entry/exit signalling on the other.
interface interruption_controller_if #(
   parameter int INTERRUPTION_SIZE = 2,
   parameter int PC_WIDTH          = 32
);
   logic [INTERRUPTION_SIZE-1:0] interruption;
   logic                         interrupt_enable;
   logic                         instruction_boundary;
   logic [PC_WIDTH-1:0]          pc_in;
   logic                         return_from_interrupt;
   logic                         irq_request;
   logic                         take_interrupt;
   logic [PC_WIDTH-1:0]          vector_pc;
   logic [PC_WIDTH-1:0]          saved_pc;
   logic                         restore_pc;
   logic                         in_handler;
   logic [INTERRUPTION_SIZE-1:0] cause;

   // Controller side
   modport slave (
      input  interruption, interrupt_enable, instruction_boundary, pc_in,
             return_from_interrupt,
      output irq_request, take_interrupt, vector_pc, saved_pc, restore_pc,
             in_handler, cause
   );

   // Control unit / watchdog side
   modport master (
      output interruption, interrupt_enable, instruction_boundary, pc_in,
             return_from_interrupt,
      input  irq_request, take_interrupt, vector_pc, saved_pc, restore_pc,
             in_handler, cause
   );
endinterface

// File: rtl/interruption_controller.sv
// Interruption controller: latches watchdog events as sticky pending bits,
// arbitrates user over timer, and hands one interrupt at a time to the
// control unit at an instruction boundary (IDLE -> SERVICE -> RETURN).
module interruption_controller #(
   parameter int                INTERRUPTION_SIZE = 2,
   parameter int                PC_WIDTH          = 32,
   parameter logic [PC_WIDTH-1:0] VECTOR_USER     = 32'h0000_0100,
   parameter logic [PC_WIDTH-1:0] VECTOR_TIMER    = 32'h0000_0200
) (
   input logic                clock,
   input logic                reset,
   interruption_controller_if.slave bus
);
   localparam logic [INTERRUPTION_SIZE-1:0] C_USER  = INTERRUPTION_SIZE'(1);
   localparam logic [INTERRUPTION_SIZE-1:0] C_TIMER = INTERRUPTION_SIZE'(2);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SERVICE = 2'd1,
      ST_RETURN  = 2'd2
   } state_t;

   state_t                       r_state;
   state_t                       w_state_next;
   logic                         r_pend_user;
   logic                         r_pend_timer;
   logic                         w_pend_user_next;
   logic                         w_pend_timer_next;
   logic [INTERRUPTION_SIZE-1:0] r_prev_code;
   logic [INTERRUPTION_SIZE-1:0] r_cause;
   logic [INTERRUPTION_SIZE-1:0] w_cause_next;
   logic                         r_take;
   logic                         w_take_next;
   logic [PC_WIDTH-1:0]          r_vector;
   logic [PC_WIDTH-1:0]          w_vector_next;
   logic [PC_WIDTH-1:0]          r_saved;
   logic [PC_WIDTH-1:0]          w_saved_next;
   logic                         w_set_user;
   logic                         w_set_timer;
   logic                         w_irq;
   logic                         w_ack;

   // A code only counts on the cycle it appears, so a held code latches once.
   assign w_set_user  = (bus.interruption == C_USER)  && (r_prev_code != C_USER);
   assign w_set_timer = (bus.interruption == C_TIMER) && (r_prev_code != C_TIMER);

   // No nesting: requests are only offered from IDLE.
   assign w_irq = (r_state == ST_IDLE) && bus.interrupt_enable && (r_pend_user || r_pend_timer);
   assign w_ack = w_irq && bus.instruction_boundary;

   assign bus.irq_request    = w_irq;
   assign bus.take_interrupt = r_take;
   assign bus.vector_pc      = r_vector;
   assign bus.saved_pc       = r_saved;
   assign bus.cause          = r_cause;
   assign bus.in_handler     = (r_state != ST_IDLE);
   assign bus.restore_pc     = (r_state == ST_RETURN);

   // Next-state, pending-bit and capture logic; a fresh event on the source
   // being cleared re-sets its bit so it is not lost.
   always_comb begin
      w_state_next      = r_state;
      w_pend_user_next  = r_pend_user  || w_set_user;
      w_pend_timer_next = r_pend_timer || w_set_timer;
      w_take_next       = 1'b0;
      w_cause_next      = r_cause;
      w_vector_next     = r_vector;
      w_saved_next      = r_saved;
      case (r_state)
         ST_IDLE: begin
            if (w_ack) begin
               w_take_next  = 1'b1;
               w_state_next = ST_SERVICE;
               w_saved_next = bus.pc_in;
               if (r_pend_user) begin
                  w_cause_next     = C_USER;
                  w_vector_next    = VECTOR_USER;
                  w_pend_user_next = w_set_user;
               end else begin
                  w_cause_next      = C_TIMER;
                  w_vector_next     = VECTOR_TIMER;
                  w_pend_timer_next = w_set_timer;
               end
            end
         end
         ST_SERVICE: begin
            if (bus.return_from_interrupt) begin
               w_state_next = ST_RETURN;
            end
         end
         ST_RETURN: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any handler and pending events.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_pend_user  <= 1'b0;
         r_pend_timer <= 1'b0;
         r_prev_code  <= '0;
         r_take       <= 1'b0;
         r_cause      <= '0;
         r_vector     <= '0;
         r_saved      <= '0;
      end else begin
         r_state      <= w_state_next;
         r_pend_user  <= w_pend_user_next;
         r_pend_timer <= w_pend_timer_next;
         r_prev_code  <= bus.interruption;
         r_take       <= w_take_next;
         r_cause      <= w_cause_next;
         r_vector     <= w_vector_next;
         r_saved      <= w_saved_next;
      end
   end
endmodule
